// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM state encoding and common widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     perf_cnt_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LU_STALL   = 2'd1,
        FLUSH_HOLD = 2'd2
    } hdu_state_t;

endpackage

// File: rtl/hazard_compare.sv
// Load-use hazard comparator between the ID sources and the EX load destination.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by hazard_detect_unit.
//
// Ports:
//   ex_valid, ex_mem_read, ex_rd      - EX instruction is a real load writing ex_rd
//   id_rs1/id_rs2, id_use_rs1/rs2     - ID source indices and whether each is read
//   hazard                            - ID needs the load result that is not ready yet
module hazard_compare
    import core_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    input  logic     id_use_rs1,
    input  logic     id_use_rs2,
    output logic     hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use stall and taken-redirect flush controller with performance counters.
// Latency: stall_FU/flush assert combinationally in the detecting cycle; busy is state-based.
// Backpressure: stall_FU freezes PC and IF/ID for LU_STALL_CYCLES; flush squashes ID/EX.
//
// Ports:
//   clk, rst (sync, active-low)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 - ID source operands
//   ex_rd, ex_mem_read, ex_valid         - EX destination / load qualifier
//   ex_redirect                          - taken branch/jump resolved in EX
//   stall_FU, flush, busy                - control outputs to the stall unit
//   stall_cnt, flush_cnt                 - free-running perf counters (wrap mod 2^32)
module hazard_detect_unit
    import core_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_valid,
    input  logic        ex_redirect,
    output logic        stall_FU,
    output logic        flush,
    output logic        busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // Remaining stall cycles after the first one, loaded on entry to LU_STALL.
    localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYCLES - 1);

    hdu_state_t state;
    hdu_state_t state_nxt;
    logic [1:0] lu_cnt;
    logic [1:0] lu_cnt_nxt;
    logic       hazard;

    hazard_compare u_hazard_compare (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .hazard      (hazard)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            lu_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            lu_cnt    <= lu_cnt_nxt;
            stall_cnt <= stall_cnt + CNT_W'(stall_FU);
            flush_cnt <= flush_cnt + CNT_W'(flush);
        end
    end

    always_comb begin
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        stall_FU   = 1'b0;
        flush      = 1'b0;

        if (!rst) begin
            // Outputs held low; the register block performs the actual clear.
            state_nxt  = IDLE;
            lu_cnt_nxt = '0;
        end else if (ex_redirect) begin
            // A taken redirect wins over everything: any pending or new stall is
            // dropped because the instruction in ID is being squashed anyway.
            flush      = 1'b1;
            lu_cnt_nxt = '0;
            state_nxt  = (FLUSH_CYCLES == 2) ? FLUSH_HOLD : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        stall_FU = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_nxt  = LU_STALL;
                            lu_cnt_nxt = LU_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    // Hazard inputs are ignored here; the stall runs to completion.
                    stall_FU = 1'b1;
                    if (lu_cnt == 2'd1) begin
                        state_nxt  = IDLE;
                        lu_cnt_nxt = '0;
                    end else begin
                        lu_cnt_nxt = lu_cnt - 2'd1;
                    end
                end
                FLUSH_HOLD: begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt  = IDLE;
                    lu_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State is registered; the rst gate keeps busy low during the reset window too.
    assign busy = rst && (state != IDLE);

endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, load-use bubble count (legal 1..3).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, cycles flush is held per taken redirect (legal 1..2).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads that source.
REQ-007 ex_rd  input  5  destination index of the instruction in EX.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 ex_valid  input  1  EX holds a real (non-bubble) instruction.
REQ-010 ex_redirect  input  1  branch/jump resolved taken in EX this cycle.
REQ-011 stall_FU  output  1  freeze PC and IF/ID, bubble EX (drives the stall unit).
REQ-012 flush  output  1  squash ID and EX (drives the stall unit).
REQ-013 busy  output  1  FSM not in IDLE.
REQ-014 stall_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-015 SHALL implement FSM states IDLE, LU_STALL, FLUSH_HOLD.
REQ-016 hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)); index x0 SHALL never hazard.
REQ-017 In IDLE with hazard and no ex_redirect, stall_FU SHALL assert combinationally in the same cycle; if LU_STALL_CYCLES > 1, next state SHALL be LU_STALL with down-counter = LU_STALL_CYCLES-1.
REQ-018 In LU_STALL, stall_FU SHALL stay asserted; the counter decrements each cycle; the FSM returns to IDLE on the cycle the counter reads 1 (stall_FU is high for exactly LU_STALL_CYCLES consecutive cycles in total).
REQ-019 ex_redirect in any state SHALL assert flush combinationally in that cycle and force stall_FU low.
REQ-020 If FLUSH_CYCLES = 2, the FSM SHALL enter FLUSH_HOLD and keep flush high for one more cycle, then go to IDLE.
REQ-021 Simultaneous ex_redirect and hazard SHALL flush only; the stall SHALL be discarded.
REQ-022 ex_redirect during LU_STALL SHALL abort the stall and clear the counter.
REQ-023 Hazard evaluation SHALL be ignored while in LU_STALL or FLUSH_HOLD; a new stall can start only from IDLE.
REQ-024 stall_cnt SHALL increment on every cycle with stall_FU high, and flush_cnt on every cycle with flush high; both SHALL wrap modulo 2^32.
REQ-025 stall_FU and flush SHALL never be high in the same cycle.
REQ-026 busy SHALL equal (state != IDLE) and is registered.

Reset
REQ-027 While rst = 0 at a rising edge, the FSM SHALL go to IDLE and the counter and both perf counters SHALL clear to 0.
REQ-028 While rst = 0, stall_FU and flush SHALL be forced to 0 regardless of inputs, and busy = 0.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abandon the operation with no residual assertion after release.

Structure
REQ-030 The FSM state enum, 5-bit register-index width and 32-bit counter width SHALL live in shared package core_pkg.
REQ-031 The hazard comparator SHALL be a combinational sub-module, hazard_compare, instantiated once.

Verification
REQ-032 Load x5 in EX, ID reads rs1 = x5 with id_use_rs1 = 1, LU_STALL_CYCLES = 1 -> stall_FU high 1 cycle, stall_cnt = 1, busy stays 0.
REQ-033 Same stimulus with LU_STALL_CYCLES = 3 -> stall_FU high 3 consecutive cycles, busy high for cycles 2-3, stall_cnt = 3.
REQ-034 Load to x0 with ID reading x0, or id_use_rs2 = 0 with rs2 matching -> stall_FU never asserts.
REQ-035 Hazard and ex_redirect in the same cycle, FLUSH_CYCLES = 2 -> flush high 2 cycles, stall_FU 0, flush_cnt = 2, stall_cnt = 0.
REQ-036 LU_STALL_CYCLES = 3, ex_redirect in the 2nd stall cycle -> stall_FU drops, flush high, FSM returns to IDLE (FLUSH_CYCLES = 1), stall_cnt = 1.
REQ-037 rst driven 0 in the 2nd cycle of a 3-cycle stall -> next edge: busy 0, all counters 0, stall_FU 0 after release.
